// File: rtl/d_mem_responder.sv
// d_mem_responder: single-port word memory behind a req/ready handshake.
// Each accepted request waits WAIT cycles, then answers with a one-cycle
// ready pulse. Misaligned and out-of-range accesses answer with err.
module d_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] MemBytes = 32'(4 * DEPTH);
  localparam logic [3:0]  WaitLoad = 4'(WAIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWaits = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          acc_err;
  logic          in_resp;

  assign idx     = addr_q[AW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= MemBytes);
  assign in_resp = (state_q == StResp);

  // Next-state logic: accept only from idle, count wait states, then respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WaitLoad;
          state_d = (WaitLoad != 4'd0) ? StWaits : StResp;
        end
      end
      StWaits: begin
        // Saturating decrement; leave on the edge where the count hits zero.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured request registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory write on the response edge; contents survive reset by design.
  always_ff @(posedge clock) begin
    if (reset && in_resp && we_q && !acc_err) begin
      mem[idx] <= wdata_q;
    end
  end

  // Response outputs decode from registered state, so reset clears them at once.
  always_comb begin
    ready = in_resp;
    busy  = (state_q != StIdle);
    err   = in_resp && acc_err;
    rdata = 32'd0;
    if (in_resp && !we_q && !acc_err) begin
      rdata = mem[idx];
    end
  end

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed bench for d_mem_responder: a WAIT=2 instance driven from a vector
// table plus hand sequences, and a WAIT=0 instance for the fast path.
module tb_d_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        s_req = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;
  logic        s_ready, s_err, s_busy;
  logic [31:0] s_rdata;

  logic        f_req = 1'b0, f_we = 1'b0;
  logic [31:0] f_addr = 32'd0, f_wdata = 32'd0;
  logic        f_ready, f_err, f_busy;
  logic [31:0] f_rdata;

  int total = 0;
  int bad   = 0;

  d_mem_responder #(.DEPTH(256), .WAIT(2)) dut_slow (
    .clock(clock), .reset(reset), .req(s_req), .we(s_we), .addr(s_addr),
    .wdata(s_wdata), .ready(s_ready), .rdata(s_rdata), .err(s_err), .busy(s_busy)
  );

  d_mem_responder #(.DEPTH(256), .WAIT(0)) dut_fast (
    .clock(clock), .reset(reset), .req(f_req), .we(f_we), .addr(f_addr),
    .wdata(f_wdata), .ready(f_ready), .rdata(f_rdata), .err(f_err), .busy(f_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one access at a negedge; returns latency in cycles (-1 on timeout).
  task automatic access(input bit fast, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic e,
                        output logic [31:0] rd);
    logic rdy;
    if (fast) begin f_req = 1'b1; f_we = w; f_addr = a; f_wdata = d; end
    else      begin s_req = 1'b1; s_we = w; s_addr = a; s_wdata = d; end
    @(posedge clock);
    @(negedge clock);
    if (fast) f_req = 1'b0; else s_req = 1'b0;
    lat = 1;
    rdy = fast ? f_ready : s_ready;
    while (!rdy && lat < 20) begin
      @(negedge clock);
      lat++;
      rdy = fast ? f_ready : s_ready;
    end
    if (!rdy) lat = -1;
    e  = fast ? f_err : s_err;
    rd = fast ? f_rdata : s_rdata;
    @(negedge clock);
    chk("ready_single_pulse", {31'd0, fast ? f_ready : s_ready}, 32'd0);
    chk("busy_back_to_idle", {31'd0, fast ? f_busy : s_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          npulse;
    logic [31:0] seen;
    logic [7:0]  pat;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0,   32'h11111111, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h20,  32'h01020304, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h6,   32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h400, 32'h99999999, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};
    vecs[7]  = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h3,   32'h77777777, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};

    // Outputs held low while in reset, even with req asserted.
    s_req = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_busy",  {31'd0, s_busy},  32'd0);
    chk("rst_err",   {31'd0, s_err},   32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_busy_fast", {31'd0, f_busy}, 32'd0);
    s_req = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, e, rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end

    // req held and retargeted during busy: exactly one response, no recapture.
    npulse = 0;
    seen   = 32'd0;
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h10; s_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (s_ready) begin
        npulse++;
        seen = s_rdata;
      end
      if (k == 0) begin s_we = 1'b1; s_wdata = 32'h0; end
      if (k == 2) begin s_req = 1'b0; s_we = 1'b0; end
    end
    chk("busy_req_pulses", 32'(npulse), 32'd1);
    chk("busy_req_rdata", seen, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h10, 32'h0, lat, e, rd);
    chk("busy_req_no_write", rd, 32'hDEADBEEF);

    // Reset during WAITS aborts the pending write.
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h20; s_wdata = 32'hCAFEF00D;
    @(posedge clock);
    @(negedge clock);
    s_req = 1'b0; s_we = 1'b0;
    chk("abort_in_waits", {31'd0, s_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy_drop",  {31'd0, s_busy},  32'd0);
    chk("abort_ready_drop", {31'd0, s_ready}, 32'd0);
    repeat (2) @(negedge clock);
    // Request presented as reset releases is taken on the first edge.
    reset = 1'b1;
    access(1'b0, 1'b0, 32'h20, 32'h0, lat, e, rd);
    chk("post_reset_latency", 32'(lat), 32'd3);
    chk("abort_old_value", rd, 32'h01020304);
    chk("abort_err", {31'd0, e}, 32'd0);

    // WAIT=0 instance: one-cycle latency and one accept every two cycles.
    access(1'b1, 1'b1, 32'h4, 32'h12345678, lat, e, rd);
    chk("fast_wr_latency", 32'(lat), 32'd1);
    chk("fast_wr_err", {31'd0, e}, 32'd0);
    chk("fast_wr_rdata", rd, 32'd0);
    access(1'b1, 1'b0, 32'h4, 32'h0, lat, e, rd);
    chk("fast_rd_latency", 32'(lat), 32'd1);
    chk("fast_rd_rdata", rd, 32'h12345678);

    f_req = 1'b1; f_we = 1'b0; f_addr = 32'h4;
    seen = 32'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      pat[k] = f_ready;
      if (f_ready) seen = f_rdata;
    end
    f_req = 1'b0;
    chk("fast_throughput", {24'd0, pat}, 32'h55);
    chk("fast_stream_rdata", seen, 32'h12345678);
    @(negedge clock);
    @(negedge clock);
    chk("fast_idle_after", {31'd0, f_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_mem_responder.md
D_MEM_RESPONDER -- requirements
Module: d_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, means data memory size in 32-bit words (power of two, 2..1024).
REQ-002 Parameter WAIT, default 2, means wait-state cycles inserted before each response (0..15).
REQ-003 Port clock, input, width 1, is the single clock; all state updates on rising edge.
REQ-004 Port reset, input, width 1, is asynchronous and active-low.
REQ-005 Port req, input, width 1, means the initiator requests an access.
REQ-006 Port we, input, width 1, means write when 1 and read when 0; sampled with req.
REQ-007 Port addr, input, width 32, is the byte address; sampled with req.
REQ-008 Port wdata, input, width 32, is the write data; sampled with req.
REQ-009 Port ready, output, width 1, means a response is valid this cycle (1-cycle pulse).
REQ-010 Port rdata, output, width 32, is the read data; valid only when ready=1 and we was 0.
REQ-011 Port err, output, width 1, means the access faulted; valid only when ready=1.
REQ-012 Port busy, output, width 1, means a request is in flight and new req is ignored.

Function
REQ-013 FSM states SHALL be IDLE, WAITS and RESP.
REQ-014 In IDLE with req=1, the block SHALL accept the request on that edge:
- capture we, addr and wdata
- load the wait counter with WAIT
- go to WAITS if WAIT>0, else go to RESP
REQ-015 In IDLE with req=0, the block SHALL remain in IDLE.
REQ-016 In WAITS, the wait counter SHALL decrement once per cycle; on the edge where it reaches 0, the FSM SHALL go to RESP.
REQ-017 In RESP, ready SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-018 Latency from the accept edge to the ready cycle SHALL be WAIT+1 cycles.
REQ-019 busy SHALL be 1 in WAITS and RESP, and 0 in IDLE.
REQ-020 req asserted while busy=1 SHALL be ignored (not queued).
REQ-021 A new request SHALL be accepted no earlier than the first IDLE cycle after RESP; back-to-back throughput is one access per WAIT+2 cycles.
REQ-022 The word index SHALL be addr[log2(DEPTH)+1:2].
REQ-023 err SHALL be set when either condition holds:
- addr[1:0] != 0 (misaligned)
- addr >= 4*DEPTH (out of range)
REQ-024 A write SHALL update memory on the RESP edge only when err=0; a faulted write SHALL leave memory unchanged.
REQ-025 For a read, rdata SHALL equal the word stored at the word index.
REQ-026 For a faulted read, rdata SHALL be 0.
REQ-027 For a write, rdata SHALL be 0.
REQ-028 Outside RESP, rdata and err SHALL be 0.
REQ-029 The counter SHALL be 4 bits wide and SHALL NOT wrap: it stops at 0.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force:
- FSM state = IDLE, wait counter = 0
- ready = 0, err = 0, busy = 0, rdata = 0
- captured we/addr/wdata = 0
REQ-031 Memory array contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted during WAITS or RESP SHALL abort the access; a pending write SHALL NOT be performed.
REQ-033 On the first rising edge after reset deasserts, the block SHALL accept a request if req=1.

Verification
REQ-034 WAIT=2: write req, addr=0x10, wdata=0xDEADBEEF -> ready on 3rd cycle after accept, err=0; then read addr=0x10 -> rdata=0xDEADBEEF, 3-cycle latency.
REQ-035 WAIT=0: read addr=0x4 after writing 0x12345678 -> ready 1 cycle after accept; req held high gives a new accept every 2 cycles.
REQ-036 Read addr=0x6 -> ready with err=1, rdata=0; write addr=0x400 (DEPTH=256) -> err=1, and word 0 still reads its prior value.
REQ-037 req pulses during busy -> no extra ready pulses; exactly one response per accepted request.
REQ-038 Write 0xCAFEF00D to 0x20, then pull reset low during WAITS -> busy/ready drop immediately; a subsequent read of 0x20 returns the old value.
REQ-039 Write addr=0x3FC (last word) with 0xA5A5A5A5 -> err=0; read back 0xA5A5A5A5; addr=0x3FC+4 -> err=1.
